// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one HI/LO-class instruction at a time onto the shared
// multi-cycle multiplier/divider, stalls the pipeline while the unit works,
// and commits the 64-bit result into the architectural HI/LO registers.
//
// Unit handshake: the controller raises <unit>_start_o the edge after the
// instruction is accepted and holds it as a level until either the unit's
// ready level is sampled high (result committed at that same edge) or the
// operation is abandoned by flush or watchdog. Dropping start is the only way
// a unit is released; annul_o tells the unit the pending operation is dead.
// Only the ready/result of the unit that was started is ever looked at.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 64  // wait-state cycle budget, 8..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mul_start_o,
    output logic        div_start_o,
    output logic        signed_o,
    output logic [31:0] unit_op1_o,
    output logic [31:0] unit_op2_o,
    output logic        annul_o,
    input  logic [63:0] mul_result_i,
    input  logic        mul_ready_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o,
    output logic [1:0]  state_dbg_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    // Last watchdog count at which a missing ready still aborts.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        mul_start_q, mul_start_d;
    logic        div_start_q, div_start_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        err_q, err_d;
    logic [7:0]  wdog_q, wdog_d;

    logic        op_is_mul;
    logic        op_is_div;
    logic        op_signed;
    logic        in_wait;
    logic        sel_ready;
    logic [63:0] sel_result;
    logic        wdog_expired;

    // Decode the presented instruction and pick the started unit's response.
    always_comb begin
        op_is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
        op_is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
        op_signed    = (op_i == OP_MULT) || (op_i == OP_DIV);
        in_wait      = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT);
        sel_ready    = (state_q == S_MUL_WAIT) ? mul_ready_i  : div_ready_i;
        sel_result   = (state_q == S_MUL_WAIT) ? mul_result_i : div_result_i;
        wdog_expired = (wdog_q == WDOG_LAST);
    end

    // Pipeline-facing combinational outputs.
    always_comb begin
        stall_o = (state_q == S_IDLE && (op_is_mul || op_is_div) && !flush_i) || in_wait;
        annul_o = in_wait ? flush_i : 1'b0;
    end

    // Next-state and next-register values; flush beats ready beats watchdog.
    always_comb begin
        state_d     = state_q;
        mul_start_d = mul_start_q;
        div_start_d = div_start_q;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        err_d       = 1'b0;
        wdog_d      = wdog_q;

        case (state_q)
            S_IDLE: begin
                if (!flush_i) begin
                    if (op_is_mul || op_is_div) begin
                        op1_d       = opdata1_i;
                        op2_d       = opdata2_i;
                        signed_d    = op_signed;
                        wdog_d      = 8'd0;
                        mul_start_d = op_is_mul;
                        div_start_d = op_is_div;
                        state_d     = op_is_mul ? S_MUL_WAIT : S_DIV_WAIT;
                    end else if (op_i == OP_MTHI) begin
                        hi_d = opdata1_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = opdata1_i;
                    end
                end
            end
            S_MUL_WAIT, S_DIV_WAIT: begin
                if (flush_i) begin
                    mul_start_d = 1'b0;
                    div_start_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (sel_ready) begin
                    hi_d        = sel_result[63:32];
                    lo_d        = sel_result[31:0];
                    mul_start_d = 1'b0;
                    div_start_d = 1'b0;
                    state_d     = S_DONE;
                end else if (wdog_expired) begin
                    mul_start_d = 1'b0;
                    div_start_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            S_DONE: begin
                // The stalled instruction is still on op_i this cycle; ignore it.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, handshake and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            signed_q    <= 1'b0;
            op1_q       <= 32'd0;
            op2_q       <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            err_q       <= 1'b0;
            wdog_q      <= 8'd0;
        end else begin
            mul_start_q <= mul_start_d;
            div_start_q <= div_start_d;
            signed_q    <= signed_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    // Registered outputs.
    always_comb begin
        mul_start_o = mul_start_q;
        div_start_o = div_start_q;
        signed_o    = signed_q;
        unit_op1_o  = op1_q;
        unit_op2_o  = op2_q;
        hi_o        = hi_q;
        lo_o        = lo_q;
        err_o       = err_q;
        state_dbg_o = state_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed HI/LO instructions with hand-computed
// results; commits and watchdog aborts are checked by a monitor against an
// expected queue of {err, hi, lo}.
module tb_muldiv_ctrl;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o, mul_start_o, div_start_o, signed_o, annul_o, err_o;
    logic [31:0] unit_op1_o, unit_op2_o, hi_o, lo_o;
    logic [63:0] mul_result_i = 64'd0;
    logic        mul_ready_i = 1'b0;
    logic [63:0] div_result_i = 64'd0;
    logic        div_ready_i = 1'b0;
    logic [1:0]  state_dbg_o;

    int total = 0;
    int bad   = 0;
    logic [64:0] exp_q[$];

    muldiv_ctrl #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .flush_i      (flush_i),
        .stall_o      (stall_o),
        .mul_start_o  (mul_start_o),
        .div_start_o  (div_start_o),
        .signed_o     (signed_o),
        .unit_op1_o   (unit_op1_o),
        .unit_op2_o   (unit_op2_o),
        .annul_o      (annul_o),
        .mul_result_i (mul_result_i),
        .mul_ready_i  (mul_ready_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .err_o        (err_o),
        .state_dbg_o  (state_dbg_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a DONE cycle or an err pulse is an observable result.
    always @(negedge clk) begin
        if (rst && (state_dbg_o == ST_DONE || err_o)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got err=%0b hi=%h lo=%h with nothing expected",
                         err_o, hi_o, lo_o);
            end else begin
                check("result", {err_o, hi_o, lo_o}, exp_q.pop_front());
            end
        end
    end

    // Run one MUL/DIV op; the other unit is held ready with junk throughout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int wait_cycles, input logic [63:0] res, input logic exp_sgn);
        logic is_div;
        int   stall_cnt;
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        stall_cnt = 0;
        exp_q.push_back({1'b0, res});
        if (is_div) begin
            mul_ready_i  = 1'b1;
            mul_result_i = 64'hBADBADBA_DBADBAD0;
        end else begin
            div_ready_i  = 1'b1;
            div_result_i = 64'hBADBADBA_DBADBAD0;
        end
        op_i = op; opdata1_i = a; opdata2_i = b;
        @(negedge clk);
        if (stall_o) stall_cnt++;
        for (int i = 1; i <= wait_cycles; i++) begin
            @(posedge clk); #1;
            if (i == wait_cycles) begin
                if (is_div) begin div_ready_i = 1'b1; div_result_i = res; end
                else begin mul_ready_i = 1'b1; mul_result_i = res; end
            end
            @(negedge clk);
            if (stall_o) stall_cnt++;
            check("start_held", is_div ? div_start_o : mul_start_o, 1'b1);
            check("other_start_low", is_div ? mul_start_o : div_start_o, 1'b0);
            if (i == 1) begin
                check("signed", signed_o, exp_sgn);
                check("unit_ops", {unit_op1_o, unit_op2_o}, {a, b});
            end
        end
        @(posedge clk); #1;
        mul_ready_i = 1'b0; div_ready_i = 1'b0;
        @(negedge clk);
        check("done_state", state_dbg_o, ST_DONE);
        check("done_stall", stall_o, 1'b0);
        check("done_starts", {mul_start_o, div_start_o}, 2'b00);
        check("stall_len", stall_cnt, 1 + wait_cycles);
        @(posedge clk); #1;
        op_i = OP_NONE;
        @(negedge clk);
        check("back_idle", state_dbg_o, ST_IDLE);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outs", {stall_o, mul_start_o, div_start_o, signed_o, annul_o, err_o, state_dbg_o},
              8'd0);
        check("reset_regs", {unit_op1_o, unit_op2_o, hi_o, lo_o}, 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // MUL/DIV commits with hand-computed results.
        run_op(OP_MULTU, 32'd3, 32'd5, 5, 64'h00000000_0000000F, 1'b0);
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, 2, 64'hFFFFFFFF_FFFFFFFA, 1'b1);
        run_op(OP_DIVU, 32'd7, 32'd2, 3, {32'd1, 32'd3}, 1'b0);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b1);
        // Ready on the last watchdog cycle still commits.
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 8, 64'hFFFFFFFE_00000001, 1'b0);

        // Flush in the 2nd wait cycle together with ready: result discarded.
        op_i = OP_MULT; opdata1_i = 32'd9; opdata2_i = 32'd9;
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_annul_low", annul_o, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b1; mul_ready_i = 1'b1; mul_result_i = 64'h00000000_00000051;
        @(negedge clk);
        check("flush_annul", annul_o, 1'b1);
        @(posedge clk); #1;
        flush_i = 1'b0; mul_ready_i = 1'b0; op_i = OP_NONE;
        @(negedge clk);
        check("flush_idle", state_dbg_o, ST_IDLE);
        check("flush_stall", stall_o, 1'b0);
        check("flush_start", mul_start_o, 1'b0);
        check("flush_hilo", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);

        // MTHI then MTLO on consecutive cycles.
        @(posedge clk); #1;
        op_i = OP_MTHI; opdata1_i = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        op_i = OP_MTLO; opdata1_i = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", hi_o, 32'hDEADBEEF);
        check("mtlo_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        op_i = OP_MTHI; opdata1_i = 32'h11111111; flush_i = 1'b1;
        @(negedge clk);
        check("mtlo_lo", lo_o, 32'h12345678);
        check("idle_annul", annul_o, 1'b0);
        @(posedge clk); #1;
        op_i = OP_MULT; opdata1_i = 32'd2; opdata2_i = 32'd2;
        @(negedge clk);
        check("flushed_mthi", hi_o, 32'hDEADBEEF);
        check("flushed_mult_stall", stall_o, 1'b0);
        @(posedge clk); #1;
        op_i = OP_NONE; flush_i = 1'b0;
        @(negedge clk);
        check("flushed_mult_start", {mul_start_o, state_dbg_o}, {1'b0, ST_IDLE});

        // Watchdog: DIVU never answered; mul side ready is noise only.
        @(posedge clk); #1;
        exp_q.push_back({1'b1, 32'hDEADBEEF, 32'h12345678});
        mul_ready_i = 1'b1; mul_result_i = 64'h0123456789ABCDEF;
        op_i = OP_DIVU; opdata1_i = 32'd100; opdata2_i = 32'd0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("wdog_wait", {state_dbg_o, div_start_o, err_o}, {ST_DIV_WAIT, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        op_i = OP_NONE; mul_ready_i = 1'b0;
        @(negedge clk);
        check("wdog_abort", {state_dbg_o, div_start_o, stall_o, err_o}, {ST_IDLE, 3'b001});
        @(posedge clk); #1;
        @(negedge clk);
        check("wdog_err_pulse", err_o, 1'b0);

        // Asynchronous reset in the middle of a wait.
        @(posedge clk); #1;
        op_i = OP_MULT; opdata1_i = 32'd5; opdata2_i = 32'd6;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0; op_i = OP_NONE;
        #1;
        check("async_rst_outs", {stall_o, mul_start_o, div_start_o, signed_o, err_o, state_dbg_o}, 7'd0);
        check("async_rst_regs", {unit_op1_o, unit_op2_o, hi_o, lo_o}, 128'd0);
        @(negedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        run_op(OP_MULTU, 32'd2, 32'd2, 1, 64'd4, 1'b0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer sitting between the EX stage and the shared multi-cycle multiplier and divider units. It accepts one HI/LO-class instruction at a time and drives the selected unit's start/annul handshake. It stalls the pipeline until the result returns, then commits the result into the architectural HI/LO registers it owns. It also handles pipeline flush mid-operation and enforces a watchdog on unresponsive units.

## Interface
- TIMEOUT, 64: max cycles spent in a wait state before abort; range 8..255.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_i  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 treated as none.
- opdata1_i  in  32  rs operand; also the MTHI/MTLO source.
- opdata2_i  in  32  rt operand.
- flush_i  in  1  pipeline flush; kills the current instruction.
- stall_o  out  1  combinational; holds EX and upstream stages.
- mul_start_o / div_start_o  out  1  registered unit start levels.
- signed_o  out  1  registered; 1 for MULT/DIV.
- unit_op1_o / unit_op2_o  out  32  registered operand copies.
- annul_o  out  1  combinational; equals flush_i while in a wait state, else 0.
- mul_result_i  in  64  multiplier product {hi,lo}.
- mul_ready_i  in  1  multiplier result-valid level.
- div_result_i  in  64  divider result {remainder,quotient}.
- div_ready_i  in  1  divider result-valid level.
- hi_o / lo_o  out  32  architectural HI/LO.
- err_o  out  1  registered one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- IDLE, op MULT/MULTU, no flush:
  - Register op1/op2/signed, set mul_start_o=1, clear wdog to 0, go to MUL_WAIT.
  - DIV/DIVU does the same with div_start_o and DIV_WAIT.
- IDLE, MTHI/MTLO, no flush: write opdata1_i to hi/lo at the edge; no stall; stay in IDLE.
- IDLE with flush_i=1: no action, no write.
- MUL_WAIT/DIV_WAIT: the start level is held at 1. wdog increments each cycle.
  - When the selected ready_i=1: hi<=result[63:32], lo<=result[31:0], start<=0, go to DONE.
  - Dropping start returns the unit to free.
- Flush in a wait state:
  - annul_o=1 that cycle. Start<=0, go to IDLE. HI/LO unchanged.
  - Flush has priority over a simultaneous ready; the result is discarded.
- Watchdog: wdog==TIMEOUT-1 without ready means start<=0, err_o pulses, go to IDLE, HI/LO unchanged.
- DONE: start=0, stall_o=0. op_i is ignored because the same instruction is still presented. Go to IDLE.
- The non-selected unit's ready/result are ignored in every state.
- Divide-by-zero results are committed as returned by the divider; no checking here.

## Timing
- stall_o = (IDLE & op in {MULT,MULTU,DIV,DIVU} & !flush_i) | MUL_WAIT | DIV_WAIT.
- Start is asserted the edge after the op is accepted. The unit must see start for at least 1 edge; it is held until ready or abort.
- Commit happens at the edge that samples ready=1. hi_o/lo_o show the new value from the DONE cycle.
- Stall length = 1 (accept cycle) + cycles spent in wait including the ready-sampling cycle. DONE is the release cycle.
- A back-to-back HI/LO op is accepted earliest in the IDLE cycle after DONE.
- Reset (any time, including mid-operation): state=IDLE, all start=0, signed_o=0, unit ops=0, hi_o=lo_o=0, err_o=0, wdog=0. Units are recovered via dropped start.
- Arithmetic: wdog is 8-bit, no wrap (abort occurs first).

## Test plan
- MULTU 3×5, mul_ready after 5 wait cycles -> stall_o high 6 cycles, then DONE; hi=0x00000000, lo=0x0000000F; signed_o=0.
- MULT 0xFFFFFFFE×3 -> signed_o=1; hi=0xFFFFFFFF, lo=0xFFFFFFFA; mul_start_o drops the edge ready is sampled.
- DIVU 7/2 with div_result={1,3} -> hi=1, lo=3; mul_start_o never asserts; an asserted mul_ready_i is ignored.
- MULT, then flush_i in 2nd wait cycle coincident with ready -> annul_o=1 that cycle, IDLE next, hi/lo keep prior values, stall_o=0.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> no stall, hi_o/lo_o updated one edge after each; with flush_i=1 -> no write.
- TIMEOUT=8, ready never asserted -> err_o pulses after 8 wait cycles, start=0, IDLE, HI/LO unchanged; rst low mid-wait clears all outputs asynchronously.
